// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: arbitrates, registers the
// chosen operation, samples the ALU one cycle later and holds the result until taken.
module alu_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_ctl,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req0_c,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_ctl,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [31:0] req1_c,

  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_data,
  output logic        rsp0_zero,

  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_data,
  output logic        rsp1_zero,

  output logic [3:0]  alu_ctl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [31:0] alu_c,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,

  output logic        busy,
  output logic [15:0] ops_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_grant;   // requester owning the in-flight operation
  logic        r_last;    // requester served by the last completed handshake
  logic [3:0]  r_ctl;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_c;
  logic [31:0] r_res;
  logic        r_zero;
  logic [15:0] r_ops_done;

  logic        w_grant;
  logic        w_idle;
  logic        w_accept;
  logic        w_rsp_hs;

  // NOTE: every variable assigned in always_comb gets a default first, so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_grant = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant = RR_EN ? ~r_last : 1'b0;
    end else if (req1_valid) begin
      w_grant = 1'b1;
    end
  end

  // Ready is gated by rst_n so nothing looks accepted while reset is held.
  assign w_idle     = rst_n && (r_state == IDLE);
  assign w_accept   = w_idle && (req0_valid || req1_valid);
  assign req0_ready = w_idle && req0_valid && !w_grant;
  assign req1_ready = w_idle && req1_valid &&  w_grant;

  assign w_rsp_hs   = (r_state == RESP) && (r_grant ? rsp1_ready : rsp0_ready);

  // NOTE: state is updated with non-blocking assignments only, so every register
  // here samples the pre-edge values regardless of statement order.
  // NOTE: all registers, including operand and result words, are reset because they
  // drive visible outputs that must read zero after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_grant    <= 1'b0;
      r_last     <= 1'b1;
      r_ctl      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_c        <= '0;
      r_res      <= '0;
      r_zero     <= 1'b0;
      r_ops_done <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_grant <= w_grant;
            r_ctl   <= w_grant ? req1_ctl : req0_ctl;
            r_a     <= w_grant ? req1_a   : req0_a;
            r_b     <= w_grant ? req1_b   : req0_b;
            r_c     <= w_grant ? req1_c   : req0_c;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_res   <= alu_out;
          r_zero  <= alu_zero;
          r_state <= RESP;
        end
        RESP: begin
          if (w_rsp_hs) begin
            r_last     <= r_grant;
            r_ops_done <= r_ops_done + 16'd1;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign alu_ctl    = r_ctl;
  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_c      = r_c;

  assign rsp0_valid = (r_state == RESP) && !r_grant;
  assign rsp1_valid = (r_state == RESP) &&  r_grant;
  assign rsp0_data  = r_res;
  assign rsp1_data  = r_res;
  assign rsp0_zero  = r_zero;
  assign rsp1_zero  = r_zero;

  assign busy       = (r_state != IDLE);
  assign ops_done   = r_ops_done;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a round-robin and a fixed-priority instance share stimulus;
// a transaction-level model predicts grants, results and the handshake count.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic        use_fp;

  logic        req0_valid, req1_valid;
  logic [3:0]  req0_ctl, req1_ctl;
  logic [31:0] req0_a, req0_b, req0_c, req1_a, req1_b, req1_c;
  logic        rsp0_ready, rsp1_ready;

  logic        rr_req0_ready, rr_req1_ready, rr_rsp0_valid, rr_rsp1_valid;
  logic        rr_rsp0_zero, rr_rsp1_zero, rr_busy, rr_alu_zero;
  logic [31:0] rr_rsp0_data, rr_rsp1_data, rr_alu_a, rr_alu_b, rr_alu_c, rr_alu_out;
  logic [3:0]  rr_alu_ctl;
  logic [15:0] rr_ops_done;

  logic        fp_req0_ready, fp_req1_ready, fp_rsp0_valid, fp_rsp1_valid;
  logic        fp_rsp0_zero, fp_rsp1_zero, fp_busy, fp_alu_zero;
  logic [31:0] fp_rsp0_data, fp_rsp1_data, fp_alu_a, fp_alu_b, fp_alu_c, fp_alu_out;
  logic [3:0]  fp_alu_ctl;
  logic [15:0] fp_ops_done;

  int          passed;
  int          total;
  int          last_served;
  logic [15:0] ops_model;

  // Shared ALU behaviour: a few decoded opcodes, zero for everything else.
  function automatic logic [31:0] alu_f(input logic [3:0] ctl, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] c);
    case (ctl)
      4'd0:    return a & b;
      4'd2:    return a + b;
      4'd6:    return a - b;
      4'd7:    return (a < b) ? 32'd1 : 32'd0;
      4'd10:   return a * b + c;
      4'd13:   return a | b;
      default: return 32'd0;
    endcase
  endfunction

  assign rr_alu_out  = alu_f(rr_alu_ctl, rr_alu_a, rr_alu_b, rr_alu_c);
  assign rr_alu_zero = (rr_alu_out == 32'd0);
  assign fp_alu_out  = alu_f(fp_alu_ctl, fp_alu_a, fp_alu_b, fp_alu_c);
  assign fp_alu_zero = (fp_alu_out == 32'd0);

  alu_arbiter #(.RR_EN(1'b1)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(rr_req0_ready), .req0_ctl(req0_ctl),
    .req0_a(req0_a), .req0_b(req0_b), .req0_c(req0_c),
    .req1_valid(req1_valid), .req1_ready(rr_req1_ready), .req1_ctl(req1_ctl),
    .req1_a(req1_a), .req1_b(req1_b), .req1_c(req1_c),
    .rsp0_valid(rr_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rr_rsp0_data), .rsp0_zero(rr_rsp0_zero),
    .rsp1_valid(rr_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rr_rsp1_data), .rsp1_zero(rr_rsp1_zero),
    .alu_ctl(rr_alu_ctl), .alu_a(rr_alu_a), .alu_b(rr_alu_b), .alu_c(rr_alu_c),
    .alu_out(rr_alu_out), .alu_zero(rr_alu_zero),
    .busy(rr_busy), .ops_done(rr_ops_done)
  );

  alu_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_ctl(req0_ctl),
    .req0_a(req0_a), .req0_b(req0_b), .req0_c(req0_c),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_ctl(req1_ctl),
    .req1_a(req1_a), .req1_b(req1_b), .req1_c(req1_c),
    .rsp0_valid(fp_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(fp_rsp0_data), .rsp0_zero(fp_rsp0_zero),
    .rsp1_valid(fp_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(fp_rsp1_data), .rsp1_zero(fp_rsp1_zero),
    .alu_ctl(fp_alu_ctl), .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_c(fp_alu_c),
    .alu_out(fp_alu_out), .alu_zero(fp_alu_zero),
    .busy(fp_busy), .ops_done(fp_ops_done)
  );

  // Observed view: whichever instance the current scenario targets.
  logic [1:0]  o_req_ready, o_rsp_valid, o_rsp_zero;
  logic [31:0] o_rsp0_data, o_rsp1_data, o_alu_a, o_alu_b, o_alu_c;
  logic [3:0]  o_alu_ctl;
  logic        o_busy;
  logic [15:0] o_ops;

  assign o_req_ready = use_fp ? {fp_req1_ready, fp_req0_ready} : {rr_req1_ready, rr_req0_ready};
  assign o_rsp_valid = use_fp ? {fp_rsp1_valid, fp_rsp0_valid} : {rr_rsp1_valid, rr_rsp0_valid};
  assign o_rsp_zero  = use_fp ? {fp_rsp1_zero, fp_rsp0_zero}   : {rr_rsp1_zero, rr_rsp0_zero};
  assign o_rsp0_data = use_fp ? fp_rsp0_data : rr_rsp0_data;
  assign o_rsp1_data = use_fp ? fp_rsp1_data : rr_rsp1_data;
  assign o_alu_ctl   = use_fp ? fp_alu_ctl   : rr_alu_ctl;
  assign o_alu_a     = use_fp ? fp_alu_a     : rr_alu_a;
  assign o_alu_b     = use_fp ? fp_alu_b     : rr_alu_b;
  assign o_alu_c     = use_fp ? fp_alu_c     : rr_alu_c;
  assign o_busy      = use_fp ? fp_busy      : rr_busy;
  assign o_ops       = use_fp ? fp_ops_done  : rr_ops_done;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_served = 1;
    ops_model = 16'd0;
  endtask

  // One complete transaction: offer, accept, execute, respond (after 'delay' stalled
  // cycles), handshake. Valids stay up for the whole transaction.
  task automatic do_op(input bit v0, input bit v1,
                       input logic [3:0] ctl0, input logic [31:0] a0, input logic [31:0] b0, input logic [31:0] c0,
                       input logic [3:0] ctl1, input logic [31:0] a1, input logic [31:0] b1, input logic [31:0] c1,
                       input int delay, input bit late_v0);
    int          g;
    logic [3:0]  e_ctl;
    logic [31:0] e_a, e_b, e_c, e_d, got_d;
    logic [1:0]  e_ready, e_vld;
    logic        got_z;
    if (v0 && v1) g = use_fp ? 0 : 1 - last_served;
    else          g = v0 ? 0 : 1;
    e_ctl   = (g == 1) ? ctl1 : ctl0;
    e_a     = (g == 1) ? a1 : a0;
    e_b     = (g == 1) ? b1 : b0;
    e_c     = (g == 1) ? c1 : c0;
    e_d     = alu_f(e_ctl, e_a, e_b, e_c);
    e_ready = {v1 && (g == 1), v0 && (g == 0)};
    e_vld   = (g == 1) ? 2'b10 : 2'b01;

    @(negedge clk);
    req0_valid = v0; req0_ctl = ctl0; req0_a = a0; req0_b = b0; req0_c = c0;
    req1_valid = v1; req1_ctl = ctl1; req1_a = a1; req1_b = b1; req1_c = c1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
    total++; if ({o_busy, o_req_ready} !== {1'b0, e_ready}) $display("FAIL accept_ready: got busy/ready %b/%b exp 0/%b", o_busy, o_req_ready, e_ready); else passed++;

    @(negedge clk);
    if (late_v0) req0_valid = 1'b1;
    #1;
    total++; if ({o_busy, o_rsp_valid, o_req_ready} !== 5'b1_00_00) $display("FAIL exec_state: got busy/rsp_valid/req_ready %b/%b/%b exp 1/00/00", o_busy, o_rsp_valid, o_req_ready); else passed++;
    total++; if ({o_alu_ctl, o_alu_a, o_alu_b, o_alu_c} !== {e_ctl, e_a, e_b, e_c}) $display("FAIL alu_operands: got %h %h %h %h exp %h %h %h %h", o_alu_ctl, o_alu_a, o_alu_b, o_alu_c, e_ctl, e_a, e_b, e_c); else passed++;

    @(negedge clk); #1;
    got_d = (g == 1) ? o_rsp1_data : o_rsp0_data;
    got_z = (g == 1) ? o_rsp_zero[1] : o_rsp_zero[0];
    total++; if ({o_rsp_valid, o_req_ready} !== {e_vld, 2'b00}) $display("FAIL resp_valid: got rsp_valid/req_ready %b/%b exp %b/00", o_rsp_valid, o_req_ready, e_vld); else passed++;
    total++; if ({got_d, got_z} !== {e_d, (e_d == 32'd0)}) $display("FAIL resp_data: got %h z=%b exp %h z=%b (grant %0d ctl %0d)", got_d, got_z, e_d, (e_d == 32'd0), g, e_ctl); else passed++;

    for (int i = 0; i < delay; i++) begin
      if (g == 1) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
      @(negedge clk); #1;
      got_d = (g == 1) ? o_rsp1_data : o_rsp0_data;
      total++; if ({o_rsp_valid, o_req_ready, got_d, o_ops} !== {e_vld, 2'b00, e_d, ops_model}) $display("FAIL resp_hold: got vld %b rdy %b data %h ops %h exp %b 00 %h %h", o_rsp_valid, o_req_ready, got_d, o_ops, e_vld, e_d, ops_model); else passed++;
    end

    rsp0_ready = (g == 0); rsp1_ready = (g == 1);
    @(negedge clk); #1;
    last_served = g;
    ops_model   = ops_model + 16'd1;
    total++; if ({o_busy, o_rsp_valid, o_ops} !== {1'b0, 2'b00, ops_model}) $display("FAIL handshake: got busy %b vld %b ops %h exp 0 00 %h", o_busy, o_rsp_valid, o_ops, ops_model); else passed++;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  task automatic test_reset();
    use_fp = 1'b0;
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++; if ({rr_req0_ready, rr_req1_ready, fp_req0_ready, fp_req1_ready} !== 4'b0000) $display("FAIL reset_ready: got %b exp 0000", {rr_req0_ready, rr_req1_ready, fp_req0_ready, fp_req1_ready}); else passed++;
    total++; if ({rr_busy, rr_rsp0_valid, rr_rsp1_valid, rr_ops_done, fp_busy, fp_ops_done} !== 35'd0) $display("FAIL reset_state: got busy %b vld %b%b ops %h fp_busy %b fp_ops %h exp all 0", rr_busy, rr_rsp0_valid, rr_rsp1_valid, rr_ops_done, fp_busy, fp_ops_done); else passed++;
    total++; if ({rr_alu_ctl, rr_alu_a, rr_alu_b, rr_alu_c} !== 100'd0) $display("FAIL reset_alu: got %h %h %h %h exp 0", rr_alu_ctl, rr_alu_a, rr_alu_b, rr_alu_c); else passed++;
    apply_reset();
  endtask

  task automatic test_single_op();
    use_fp = 1'b0;
    apply_reset();
    do_op(1'b1, 1'b0, 4'd2, 32'd5, 32'd7, 32'd0, 4'd0, 32'd0, 32'd0, 32'd0, 0, 1'b0);
    total++; if (rr_rsp0_data !== 32'd12) $display("FAIL single_op_data: got %h exp 0000000c", rr_rsp0_data); else passed++;
  endtask

  task automatic test_rr_contention();
    use_fp = 1'b0;
    apply_reset();
    for (int k = 0; k < 4; k++)
      do_op(1'b1, 1'b1, 4'd6, 32'd9, 32'd9, 32'd0, 4'd13, 32'hF0, 32'h0F, 32'd0, 0, 1'b0);
    total++; if (rr_rsp1_data !== 32'hFF) $display("FAIL rr_last_result: got %h exp 000000ff", rr_rsp1_data); else passed++;
  endtask

  task automatic test_fixed_priority();
    use_fp = 1'b1;
    apply_reset();
    for (int k = 0; k < 3; k++)
      do_op(1'b1, 1'b1, 4'd2, 32'd100 + k, 32'd1, 32'd0, 4'd13, 32'h1, 32'h2, 32'd0, 0, 1'b0);
    total++; if (fp_ops_done !== 16'd3) $display("FAIL fp_count: got %h exp 0003", fp_ops_done); else passed++;
    use_fp = 1'b0;
  endtask

  task automatic test_backpressure();
    use_fp = 1'b0;
    apply_reset();
    do_op(1'b0, 1'b1, 4'd0, 32'd0, 32'd0, 32'd0, 4'd10, 32'd3, 32'd4, 32'd1, 5, 1'b1);
    total++; if (rr_rsp1_data !== 32'd13) $display("FAIL bp_data: got %h exp 0000000d", rr_rsp1_data); else passed++;
    do_op(1'b1, 1'b0, 4'd7, 32'd2, 32'd9, 32'd0, 4'd0, 32'd0, 32'd0, 32'd0, 1, 1'b0);
  endtask

  task automatic test_drop_before_grant();
    logic [31:0] prev_a;
    use_fp = 1'b0;
    prev_a = o_alu_a;
    @(negedge clk);
    req1_valid = 1'b1; req1_ctl = 4'd2; req1_a = 32'd77; req1_b = 32'd1; req1_c = 32'd0;
    #2 req1_valid = 1'b0;
    @(negedge clk); #1;
    total++; if ({o_busy, o_rsp_valid, o_alu_a} !== {1'b0, 2'b00, prev_a}) $display("FAIL drop_valid: got busy %b vld %b alu_a %h exp 0 00 %h", o_busy, o_rsp_valid, o_alu_a, prev_a); else passed++;
  endtask

  task automatic test_reset_mid_op();
    bit seen;
    use_fp = 1'b0;
    apply_reset();
    do_op(1'b1, 1'b0, 4'd2, 32'd1, 32'd1, 32'd0, 4'd0, 32'd0, 32'd0, 32'd0, 0, 1'b0);
    @(negedge clk);
    req0_valid = 1'b1; req0_ctl = 4'd2; req0_a = 32'd40; req0_b = 32'd2; req0_c = 32'd3;
    repeat (2) @(negedge clk);
    #1;
    total++; if (rr_rsp0_valid !== 1'b1) $display("FAIL midop_reached_resp: got %b exp 1", rr_rsp0_valid); else passed++;
    rst_n = 1'b0;
    @(negedge clk); #1;
    total++; if ({rr_busy, rr_rsp0_valid, rr_rsp1_valid, rr_req0_ready, rr_ops_done} !== 20'd0) $display("FAIL midop_reset: got busy %b vld %b%b rdy %b ops %h exp all 0", rr_busy, rr_rsp0_valid, rr_rsp1_valid, rr_req0_ready, rr_ops_done); else passed++;
    total++; if ({rr_alu_ctl, rr_alu_a, rr_alu_b, rr_alu_c} !== 100'd0) $display("FAIL midop_alu: got %h %h %h %h exp 0", rr_alu_ctl, rr_alu_a, rr_alu_b, rr_alu_c); else passed++;
    req0_valid = 1'b0;
    rsp0_ready = 1'b1;
    rst_n = 1'b1;
    last_served = 1; ops_model = 16'd0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (rr_rsp0_valid || rr_rsp1_valid) seen = 1'b1;
    end
    rsp0_ready = 1'b0;
    total++; if ({seen, rr_ops_done} !== 17'd0) $display("FAIL midop_discard: got rsp seen %b ops %h exp 0 0000", seen, rr_ops_done); else passed++;
  endtask

  task automatic test_wrap();
    use_fp = 1'b0;
    apply_reset();
    @(negedge clk);
    force dut_rr.r_ops_done = 16'hFFFF;
    @(negedge clk);
    release dut_rr.r_ops_done;
    @(negedge clk); #1;
    total++; if (rr_ops_done !== 16'hFFFF) $display("FAIL wrap_preload: got %h exp ffff", rr_ops_done); else passed++;
    ops_model = 16'hFFFF;
    do_op(1'b0, 1'b1, 4'd2, 32'd0, 32'd0, 32'd0, 4'd6, 32'd10, 32'd3, 32'd0, 0, 1'b0);
    total++; if (rr_ops_done !== 16'h0000) $display("FAIL wrap_result: got %h exp 0000", rr_ops_done); else passed++;
  endtask

  task automatic test_random(input bit fp, input int n);
    int          r;
    logic [31:0] op [6];
    use_fp = fp;
    apply_reset();
    for (int k = 0; k < n; k++) begin
      r = $urandom_range(1, 3);
      for (int j = 0; j < 6; j++)
        op[j] = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 3));
      do_op(r[0], r[1], 4'($urandom_range(0, 15)), op[0], op[1], op[2],
            4'($urandom_range(0, 15)), op[3], op[4], op[5],
            $urandom_range(0, 3), 1'b0);
    end
    use_fp = 1'b0;
  endtask

  initial begin
    passed = 0; total = 0;
    use_fp = 1'b0; rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_ctl = '0; req0_a = '0; req0_b = '0; req0_c = '0;
    req1_ctl = '0; req1_a = '0; req1_b = '0; req1_c = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    last_served = 1; ops_model = 16'd0;

    test_reset();
    test_single_op();
    test_drop_before_grant();
    test_rr_contention();
    test_fixed_priority();
    test_backpressure();
    test_reset_mid_op();
    test_wrap();
    test_random(1'b0, 30);
    test_random(1'b1, 12);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
